// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC/fetch sequencer.
package pc_fetch_unit_pkg;

   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_REQ   = 2'd1;
   localparam logic [1:0]  ST_HOLD  = 2'd2;
   localparam logic [1:0]  ST_DROP  = 2'd3;

   localparam logic [31:0] PC_STEP  = 32'd4;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_REQ  = ST_REQ,
      S_HOLD = ST_HOLD,
      S_DROP = ST_DROP
   } fetch_state_e;

   typedef enum logic [1:0] {
      SEL_SEQ   = 2'd0,
      SEL_REDIR = 2'd1,
      SEL_PEND  = 2'd2
   } pc_sel_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control, instruction-memory and decode handshake signals of the fetch unit.
interface pc_fetch_unit_if;
   logic        Stall;
   logic        Redirect;
   logic [31:0] Redirect_PC;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic        Imem_Ack;
   logic [31:0] Imem_Rdata;
   logic        Inst_Valid;
   logic [31:0] Inst;
   logic [31:0] Inst_PC;
   logic        Inst_Ready;

   modport master (
      input  Stall, Redirect, Redirect_PC, Imem_Ack, Imem_Rdata, Inst_Ready,
      output Imem_Req, Imem_Addr, Inst_Valid, Inst, Inst_PC
   );

   modport slave (
      output Stall, Redirect, Redirect_PC, Imem_Ack, Imem_Rdata, Inst_Ready,
      input  Imem_Req, Imem_Addr, Inst_Valid, Inst, Inst_PC
   );
endinterface

// File: rtl/pc_fetch_unit_next_sel.sv
// Next-PC mux: sequential PC+4, redirect target or pending target, word aligned.
module pc_next_sel
   import pc_fetch_unit_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [31:0] i_redirect_pc,
   input  logic [31:0] i_pend_pc,
   input  pc_sel_e     i_sel,
   output logic [31:0] o_pc_seq,
   output logic [31:0] o_pc_next
);

   logic [31:0] w_mux;

   assign o_pc_seq = i_pc + PC_STEP;

   always_comb begin
      w_mux = o_pc_seq;
      case (i_sel)
         SEL_REDIR: w_mux = i_redirect_pc;
         SEL_PEND:  w_mux = i_pend_pc;
         default:   w_mux = o_pc_seq;
      endcase
   end

   assign o_pc_next = {w_mux[31:2], 2'b00};

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC owner and single-outstanding instruction fetch sequencer.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic             CLK,
   input  logic             RST,
   pc_fetch_unit_if.master  bus
);

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_pend_pc;
   logic         r_inst_vld;
   logic [31:0]  r_inst;
   logic [31:0]  r_inst_pc;

   pc_sel_e      w_sel;
   logic [31:0]  w_pc_seq;
   logic [31:0]  w_pc_next;
   fetch_state_e w_exit;

   // In S_DROP a fresh redirect overrides the stored target.
   always_comb begin
      w_sel = SEL_SEQ;
      if (r_state == S_DROP && !bus.Redirect) w_sel = SEL_PEND;
      else if (bus.Redirect)                  w_sel = SEL_REDIR;
   end

   assign w_exit = bus.Stall ? S_IDLE : S_REQ;

   pc_next_sel u_next_sel (
      .i_pc          (r_pc),
      .i_redirect_pc (bus.Redirect_PC),
      .i_pend_pc     (r_pend_pc),
      .i_sel         (w_sel),
      .o_pc_seq      (w_pc_seq),
      .o_pc_next     (w_pc_next)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_pend_pc  <= '0;
         r_inst_vld <= 1'b0;
         r_inst     <= '0;
         r_inst_pc  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.Redirect) r_pc <= w_pc_next;
               if (!bus.Stall)   r_state <= S_REQ;
            end
            S_REQ: begin
               if (bus.Imem_Ack) begin
                  r_pc <= w_pc_next;
                  if (bus.Redirect) begin
                     r_state <= w_exit;
                  end else begin
                     r_inst     <= bus.Imem_Rdata;
                     r_inst_pc  <= r_pc;
                     r_inst_vld <= 1'b1;
                     r_state    <= S_HOLD;
                  end
               end else if (bus.Redirect) begin
                  // Address must stay put until the orphan request is acked.
                  r_pend_pc <= bus.Redirect_PC;
                  r_state   <= S_DROP;
               end
            end
            S_DROP: begin
               if (bus.Imem_Ack) begin
                  r_pc    <= w_pc_next;
                  r_state <= w_exit;
               end else if (bus.Redirect) begin
                  r_pend_pc <= bus.Redirect_PC;
               end
            end
            S_HOLD: begin
               if (bus.Redirect) begin
                  r_inst_vld <= 1'b0;
                  r_pc       <= w_pc_next;
                  r_state    <= w_exit;
               end else if (bus.Inst_Ready) begin
                  r_inst_vld <= 1'b0;
                  r_state    <= w_exit;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.Imem_Req   = (r_state == S_REQ) || (r_state == S_DROP);
   assign bus.Imem_Addr  = r_pc;
   assign bus.Inst_Valid = r_inst_vld;
   assign bus.Inst       = r_inst;
   assign bus.Inst_PC    = r_inst_pc;

   logic w_unused;
   assign w_unused = ^w_pc_seq;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit; memory returns 0xC0DE_<addr[15:0]>.
module tb_pc_fetch_unit;
   import pc_fetch_unit_pkg::*;

   logic CLK;
   logic RST;
   int   checks;
   int   errors;

   pc_fetch_unit_if bus ();

   pc_fetch_unit #(.RESET_PC(32'h0)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign bus.Imem_Rdata = 32'hC0DE_0000 | {16'h0, bus.Imem_Addr[15:0]};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.Redirect_PC = '0;
      bus.Imem_Ack = 1'b0; bus.Inst_Ready = 1'b1;
      step();
      step();
      RST = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // reset values
      do_reset();
      chk("rst_req",   {31'b0, bus.Imem_Req},   32'h0);
      chk("rst_addr",  bus.Imem_Addr,           32'h0);
      chk("rst_vld",   {31'b0, bus.Inst_Valid}, 32'h0);
      chk("rst_inst",  bus.Inst,                32'h0);
      chk("rst_ipc",   bus.Inst_PC,             32'h0);

      // streaming: Ack and Ready tied high
      bus.Imem_Ack = 1'b1;
      step();
      chk("s_req0",  {31'b0, bus.Imem_Req}, 32'h1);
      chk("s_addr0", bus.Imem_Addr, 32'h0);
      step();
      chk("s_vld0",  {31'b0, bus.Inst_Valid}, 32'h1);
      chk("s_inst0", bus.Inst, 32'hC0DE_0000);
      chk("s_ipc0",  bus.Inst_PC, 32'h0);
      chk("s_noreq", {31'b0, bus.Imem_Req}, 32'h0);
      step();
      chk("s_addr1", bus.Imem_Addr, 32'h4);
      chk("s_req1",  {31'b0, bus.Imem_Req}, 32'h1);
      step();
      chk("s_inst1", bus.Inst, 32'hC0DE_0004);
      chk("s_ipc1",  bus.Inst_PC, 32'h4);
      step();
      chk("s_addr2", bus.Imem_Addr, 32'h8);

      // Ack delayed 3 cycles
      do_reset();
      step();
      for (int i = 0; i < 3; i++) begin
         chk("d_req",  {31'b0, bus.Imem_Req}, 32'h1);
         chk("d_addr", bus.Imem_Addr, 32'h0);
         chk("d_vld",  {31'b0, bus.Inst_Valid}, 32'h0);
         step();
      end
      bus.Imem_Ack = 1'b1;
      chk("d_vld_pre", {31'b0, bus.Inst_Valid}, 32'h0);
      step();
      bus.Imem_Ack = 1'b0;
      chk("d_vld_post", {31'b0, bus.Inst_Valid}, 32'h1);
      chk("d_inst",     bus.Inst, 32'hC0DE_0000);

      // redirect with request outstanding, Ack two cycles later
      do_reset();
      step();
      bus.Redirect = 1'b1; bus.Redirect_PC = 32'h100;
      step();
      bus.Redirect = 1'b0;
      chk("r_drop_req",  {31'b0, bus.Imem_Req}, 32'h1);
      chk("r_drop_addr", bus.Imem_Addr, 32'h0);
      step();
      chk("r_drop_addr2", bus.Imem_Addr, 32'h0);
      bus.Imem_Ack = 1'b1;
      step();
      chk("r_novld",  {31'b0, bus.Inst_Valid}, 32'h0);
      chk("r_tgt",    bus.Imem_Addr, 32'h100);
      chk("r_treq",   {31'b0, bus.Imem_Req}, 32'h1);
      step();
      bus.Imem_Ack = 1'b0;
      chk("r_ipc",  bus.Inst_PC, 32'h100);
      chk("r_inst", bus.Inst, 32'hC0DE_0100);

      // latest redirect wins in S_DROP; unaligned target is cleared
      do_reset();
      step();
      bus.Redirect = 1'b1; bus.Redirect_PC = 32'h200;
      step();
      bus.Redirect_PC = 32'h300;
      step();
      bus.Redirect = 1'b0; bus.Imem_Ack = 1'b1;
      step();
      chk("l_addr", bus.Imem_Addr, 32'h300);
      bus.Redirect = 1'b1; bus.Redirect_PC = 32'h103;
      step();
      bus.Redirect = 1'b0;
      chk("l_novld", {31'b0, bus.Inst_Valid}, 32'h0);
      chk("l_align", bus.Imem_Addr, 32'h100);
      step();
      chk("l_ipc", bus.Inst_PC, 32'h100);

      // hold with Ready low, then redirect+ready together
      do_reset();
      bus.Imem_Ack = 1'b1; bus.Inst_Ready = 1'b0;
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         chk("h_vld",  {31'b0, bus.Inst_Valid}, 32'h1);
         chk("h_inst", bus.Inst, 32'hC0DE_0000);
         chk("h_req",  {31'b0, bus.Imem_Req}, 32'h0);
         step();
      end
      bus.Redirect = 1'b1; bus.Redirect_PC = 32'h40;
      bus.Inst_Ready = 1'b1; bus.Imem_Ack = 1'b0;
      step();
      bus.Redirect = 1'b0;
      chk("h_drop", {31'b0, bus.Inst_Valid}, 32'h0);
      chk("h_tgt",  bus.Imem_Addr, 32'h40);
      chk("h_treq", {31'b0, bus.Imem_Req}, 32'h1);

      // stall during hold, then resume at PC+4; async reset mid-request
      do_reset();
      bus.Imem_Ack = 1'b1; bus.Inst_Ready = 1'b0;
      step();
      step();
      bus.Stall = 1'b1;
      step();
      chk("st_hold", {31'b0, bus.Inst_Valid}, 32'h1);
      bus.Inst_Ready = 1'b1;
      step();
      chk("st_idle_vld", {31'b0, bus.Inst_Valid}, 32'h0);
      chk("st_idle_req", {31'b0, bus.Imem_Req}, 32'h0);
      step();
      chk("st_idle_req2", {31'b0, bus.Imem_Req}, 32'h0);
      bus.Stall = 1'b0; bus.Imem_Ack = 1'b0;
      step();
      chk("st_req",  {31'b0, bus.Imem_Req}, 32'h1);
      chk("st_addr", bus.Imem_Addr, 32'h4);
      RST = 1'b1;
      #1;
      chk("ar_req",  {31'b0, bus.Imem_Req}, 32'h0);
      chk("ar_addr", bus.Imem_Addr, 32'h0);
      chk("ar_vld",  {31'b0, bus.Inst_Valid}, 32'h0);
      chk("ar_inst", bus.Inst, 32'h0);
      chk("ar_ipc",  bus.Inst_PC, 32'h0);
      step();
      RST = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter owner and instruction-fetch sequencer for the RISC-V core. It holds the architectural PC, issues single-outstanding requests to instruction memory, and buffers the returned word for decode with a valid/ready handshake. It accepts redirect targets (jump/branch) from execute and computes the sequential PC+4 itself. It is the consumer end of the next-PC selection path: it registers the chosen next PC and feeds the sequential address back to that path.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- Stall  in  1  hold off issuing new fetch requests
- Redirect  in  1  one-cycle pulse: discard in-flight/held instruction, continue at Redirect_PC
- Redirect_PC  in  32  target address; bits [1:0] are forced to 0 on load
- Imem_Req  out  1  fetch request
- Imem_Addr  out  32  fetch address, stable while Imem_Req=1 and until Imem_Ack
- Imem_Ack  in  1  request accepted; Imem_Rdata is valid in the same cycle
- Imem_Rdata  in  32  instruction word
- Inst_Valid  out  1  Inst/Inst_PC hold a valid instruction
- Inst  out  32  instruction to decode
- Inst_PC  out  32  address of Inst
- Inst_Ready  in  1  decode consumes Inst when Inst_Valid=1 and Inst_Ready=1

## Operation
- State machine: S_IDLE, S_REQ, S_HOLD, S_DROP. Imem_Req = (S_REQ or S_DROP). Imem_Addr = PC register, except in S_DROP, where it is the unchanged address of the request being dropped.
- "Exit" below means: go to S_REQ if Stall=0, else S_IDLE.
- S_IDLE: Redirect loads PC ← {Redirect_PC[31:2],2'b00}. Stall=0 → S_REQ. The new PC is used if Redirect and Stall=0 occur in the same cycle.
- S_REQ:
  - Ack and no Redirect: Inst ← Imem_Rdata, Inst_PC ← PC, Inst_Valid ← 1, PC ← PC+4 (mod 2^32), → S_HOLD.
  - Ack and Redirect: discard data, PC ← target, exit.
  - No Ack and Redirect: Pend_PC ← target, → S_DROP. The address stays unchanged.
- S_DROP:
  - Redirect without Ack: Pend_PC ← newest target (latest wins).
  - Ack: discard data, PC ← (Redirect ? Redirect_PC : Pend_PC) with bits [1:0] cleared, exit.
- S_HOLD:
  - Redirect has priority over Inst_Ready: Inst_Valid ← 0, PC ← target, exit.
  - Inst_Ready alone: Inst_Valid ← 0, exit.
  - Otherwise hold Inst, Inst_PC and Inst_Valid stable.
- Stall never withdraws an asserted Imem_Req. It is sampled only at S_IDLE and at exits.
- At most one outstanding memory request. No data is ever delivered from a request issued before a Redirect.

## Timing
- Reset (async assert, sync release) gives: state S_IDLE, PC=RESET_PC, Pend_PC=0, Imem_Req=0, Imem_Addr=RESET_PC, Inst_Valid=0, Inst=0, Inst_PC=0.
- First Imem_Req is asserted in the cycle after the first post-reset edge that sees Stall=0.
- Ack-to-Inst_Valid latency is one cycle: the registered output is visible after the Ack edge.
- Peak throughput, with Ack in the first Req cycle and Ready held high, is one instruction per 2 cycles: S_REQ → S_HOLD → S_REQ.
- Redirect latency: the first request to the target is issued one cycle after the Redirect edge, or one cycle after the Ack in S_DROP.
- RST during any state aborts immediately. Memory must tolerate Req dropping without Ack on reset.

## Structure
- Shared package holds:
  - state encoding localparams (2-bit);
  - PC_STEP = 32'd4;
  - INST_NOP = 32'h0000_0013 for bench and pipeline-flush use.
- One sub-module, pc_next_sel: combinational. It selects the PC load value from PC+4, Redirect_PC and Pend_PC, and clears bits [1:0]. It contains no state.
- All other logic (FSM, PC, Pend_PC and output registers) lives in pc_fetch_unit.

## Test plan
- Reset release with Stall=0, Ack tied high, Ready tied high → Imem_Addr sequence 0x0, 0x4, 0x8 on alternate cycles. Inst_PC matches the address and Inst matches Rdata.
- Ack delayed 3 cycles → Imem_Addr stays 0x0 and Req stays high throughout. Inst_Valid rises one cycle after the Ack edge.
- Redirect to 0x100 while in S_REQ with no Ack, then Ack 2 cycles later → the returned word is never presented. Next Imem_Addr is 0x100.
- Two Redirects during S_DROP (0x200, then 0x300), then Ack → next fetch is at 0x300. Redirect to 0x103 → fetch at 0x100.
- Inst_Valid with Ready=0 for 4 cycles → Inst is stable and no Req is issued. Redirect and Ready in the same cycle → instruction dropped, fetch at the target.
- Stall=1 during S_HOLD then Ready → S_IDLE, no Req. Stall low → Req at PC+4. RST asserted mid-S_REQ → all outputs return to reset values asynchronously.
